// File: rtl/hamming_scrubber.sv
// Background SECDED scrubber: walks the memory, writes single-bit errors back
// corrected and reports double-bit errors through counters and an IRQ pulse.
module hamming_scrubber #(
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter int PAUSE_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [15:0]       mem_rdata_i,
  output logic [15:0]       corr_count_o,
  output logic [15:0]       uncorr_count_o,
  output logic [ADDR_W-1:0] last_uncorr_addr_o,
  output logic              err_irq_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_CHECK   = 3'd3,
    S_WR_REQ  = 3'd4,
    S_ADV     = 3'd5,
    S_PAUSE   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       PAUSE_LAST = 16'((PAUSE_CYCLES > 0) ? PAUSE_CYCLES - 1 : 0);

  // Returns {overall parity, error position}; position 0 with odd parity means bit 0.
  function automatic logic [4:0] syndrome(input logic [15:0] w);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (w[i]) pos = pos ^ 4'(i);
    end
    return {^w, pos};
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, last_uncorr_q;
  logic [15:0]       w_q, wdata_q, corr_q, uncorr_q, pause_q;
  logic              busy_q, done_q, req_q, we_q, irq_q;
  logic              par_d;
  logic [3:0]        pos_d;
  logic [15:0]       fix_wdata_d;

  // Syndrome and corrected word for the captured codeword.
  always_comb begin
    {par_d, pos_d} = syndrome(w_q);
    fix_wdata_d    = w_q ^ (16'd1 << pos_d);
  end

  // Scrub sequencer; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      last_uncorr_q <= '0;
      w_q           <= 16'd0;
      wdata_q       <= 16'd0;
      corr_q        <= 16'd0;
      uncorr_q      <= 16'd0;
      pause_q       <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      irq_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q   <= '0;
            corr_q   <= 16'd0;
            uncorr_q <= 16'd0;
            busy_q   <= 1'b1;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            state_q  <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid_i) begin
            w_q     <= mem_rdata_i;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (par_d) begin
            if (corr_q != 16'hFFFF) corr_q <= corr_q + 16'd1;
            wdata_q <= fix_wdata_d;
            we_q    <= 1'b1;
            req_q   <= 1'b1;
            state_q <= S_WR_REQ;
          end else if (pos_d != 4'd0) begin
            if (uncorr_q != 16'hFFFF) uncorr_q <= uncorr_q + 16'd1;
            last_uncorr_q <= addr_q;
            irq_q         <= 1'b1;
            state_q       <= S_ADV;
          end else begin
            state_q <= S_ADV;
          end
        end
        S_WR_REQ: begin
          if (mem_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_ADV;
          end
        end
        S_ADV: begin
          if (addr_q == LAST_ADDR) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            if (PAUSE_CYCLES > 0) begin
              pause_q <= 16'd0;
              state_q <= S_PAUSE;
            end else begin
              req_q   <= 1'b1;
              state_q <= S_RD_REQ;
            end
          end
        end
        S_PAUSE: begin
          if (pause_q == PAUSE_LAST) begin
            req_q   <= 1'b1;
            state_q <= S_RD_REQ;
          end else begin
            pause_q <= pause_q + 16'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign mem_req_o          = req_q;
  assign mem_we_o           = we_q;
  assign mem_addr_o         = addr_q;
  assign mem_wdata_o        = wdata_q;
  assign corr_count_o       = corr_q;
  assign uncorr_count_o     = uncorr_q;
  assign last_uncorr_addr_o = last_uncorr_q;
  assign err_irq_o          = irq_q;

endmodule

// File: tb/tb_hamming_scrubber.sv
// Directed bench for hamming_scrubber with a 4-word memory model, configurable
// grant hold-off and read latency.
module tb_hamming_scrubber;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [15:0]       mem_rdata_i = 16'd0;
  logic              busy_o, done_o, mem_req_o, mem_we_o, err_irq_o;
  logic [ADDR_W-1:0] mem_addr_o, last_uncorr_addr_o;
  logic [15:0]       mem_wdata_o, corr_count_o, uncorr_count_o;

  int total = 0;
  int bad   = 0;

  logic [15:0]       img [DEPTH];
  int                hold_n   = 0;
  int                rv_delay = 1;
  int                req_wait = 0;
  int                rd_cnt   = 0;
  logic [ADDR_W-1:0] rd_addr  = '0;
  int                n_rd = 0;
  int                n_wr = 0;
  int                irq_cnt = 0;
  logic [ADDR_W-1:0] rd_log [128];
  logic [ADDR_W-1:0] wr_addr_log [32];
  logic [15:0]       wr_data_log [32];

  hamming_scrubber #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PAUSE_CYCLES(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .corr_count_o(corr_count_o),
    .uncorr_count_o(uncorr_count_o), .last_uncorr_addr_o(last_uncorr_addr_o),
    .err_irq_o(err_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory/arbiter model: decides grant and read data mid-cycle, logs accesses.
  always @(negedge clk_i) begin
    mem_rvalid_i = 1'b0;
    if (rd_cnt != 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = img[rd_addr[1:0]];
      end
    end
    if (err_irq_o === 1'b1) irq_cnt++;
    mem_gnt_i = 1'b0;
    if (mem_req_o === 1'b1 && rst_i === 1'b0) begin
      if (req_wait < hold_n) begin
        req_wait++;
      end else begin
        mem_gnt_i = 1'b1;
        req_wait  = 0;
        if (mem_we_o) begin
          if (n_wr < 32) begin
            wr_addr_log[n_wr] = mem_addr_o;
            wr_data_log[n_wr] = mem_wdata_o;
          end
          n_wr++;
        end else begin
          rd_cnt  = rv_delay;
          rd_addr = mem_addr_o;
          if (n_rd < 128) rd_log[n_rd] = mem_addr_o;
          n_rd++;
        end
      end
    end else begin
      req_wait = 0;
    end
  end

  task automatic load_img(input logic [15:0] w0, w1, w2, w3);
    img[0] = w0; img[1] = w1; img[2] = w2; img[3] = w3;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // cyc = clock edges after the edge that sampled start, until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    total++;
    if ({busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, corr_count_o,
         uncorr_count_o, last_uncorr_addr_o, err_irq_o} !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b req=%b addr=%h corr=%h uncorr=%h last=%h, want all 0",
               busy_o, mem_req_o, mem_addr_o, corr_count_o, uncorr_count_o, last_uncorr_addr_o);
    end
  endtask

  task automatic test_clean();
    int cyc; int rb; int wb;
    load_img(16'h0000, 16'h003C, 16'h0000, 16'h0000);
    rb = n_rd; wb = n_wr;
    pulse_start();
    total++;
    if ({busy_o, mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL clean_first_req: busy=%b req=%b we=%b addr=%h want 1 1 0 00",
               busy_o, mem_req_o, mem_we_o, mem_addr_o);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 16) begin bad++; $display("FAIL clean_done_time: got %0d want 16", cyc); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL clean_busy_at_done: got %b want 0", busy_o); end
    total++;
    if (n_rd - rb !== 4) begin bad++; $display("FAIL clean_reads: got %0d want 4", n_rd - rb); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_log[rb+k] !== ADDR_W'(k)) begin
        bad++;
        $display("FAIL clean_rd_addr%0d: got %0d want %0d", k, rd_log[rb+k], k);
      end
    end
    total++;
    if (n_wr - wb !== 0) begin bad++; $display("FAIL clean_writes: got %0d want 0", n_wr - wb); end
    total++;
    if ({corr_count_o, uncorr_count_o} !== 32'd0) begin
      bad++;
      $display("FAIL clean_counts: corr=%0d uncorr=%0d want 0 0", corr_count_o, uncorr_count_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL clean_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_single_bit7();
    int cyc; int wb; int ib;
    load_img(16'h0000, 16'h0000, 16'h0080, 16'h0000);
    wb = n_wr; ib = irq_cnt;
    pulse_start();
    wait_done(cyc);
    total++;
    if (cyc !== 17) begin bad++; $display("FAIL b7_done_time: got %0d want 17", cyc); end
    total++;
    if (n_wr - wb !== 1) begin bad++; $display("FAIL b7_writes: got %0d want 1", n_wr - wb); end
    total++;
    if (wr_addr_log[wb] !== 8'd2 || wr_data_log[wb] !== 16'h0000) begin
      bad++;
      $display("FAIL b7_write: addr=%h data=%h want 02 0000", wr_addr_log[wb], wr_data_log[wb]);
    end
    total++;
    if (corr_count_o !== 16'd1 || uncorr_count_o !== 16'd0) begin
      bad++;
      $display("FAIL b7_counts: corr=%0d uncorr=%0d want 1 0", corr_count_o, uncorr_count_o);
    end
    total++;
    if (irq_cnt - ib !== 0) begin bad++; $display("FAIL b7_irq: got %0d want 0", irq_cnt - ib); end
  endtask

  task automatic test_single_bit0();
    int cyc; int wb;
    load_img(16'h0000, 16'h0001, 16'h0000, 16'h103C);
    wb = n_wr;
    pulse_start();
    wait_done(cyc);
    total++;
    if (cyc !== 18) begin bad++; $display("FAIL b0_done_time: got %0d want 18", cyc); end
    total++;
    if (n_wr - wb !== 2) begin bad++; $display("FAIL b0_writes: got %0d want 2", n_wr - wb); end
    total++;
    if (wr_addr_log[wb] !== 8'd1 || wr_data_log[wb] !== 16'h0000) begin
      bad++;
      $display("FAIL b0_write: addr=%h data=%h want 01 0000", wr_addr_log[wb], wr_data_log[wb]);
    end
    total++;
    if (wr_addr_log[wb+1] !== 8'd3 || wr_data_log[wb+1] !== 16'h003C) begin
      bad++;
      $display("FAIL b12_write: addr=%h data=%h want 03 003c", wr_addr_log[wb+1], wr_data_log[wb+1]);
    end
    total++;
    if (corr_count_o !== 16'd2) begin bad++; $display("FAIL b0_corr: got %0d want 2", corr_count_o); end
  endtask

  task automatic test_double();
    int cyc; int wb; int ib;
    load_img(16'h0000, 16'h0024, 16'h0000, 16'h0000);
    wb = n_wr; ib = irq_cnt;
    pulse_start();
    wait_done(cyc);
    total++;
    if (cyc !== 16) begin bad++; $display("FAIL dbl_done_time: got %0d want 16", cyc); end
    total++;
    if (irq_cnt - ib !== 1) begin bad++; $display("FAIL dbl_irq: got %0d want 1", irq_cnt - ib); end
    total++;
    if (uncorr_count_o !== 16'd1 || corr_count_o !== 16'd0) begin
      bad++;
      $display("FAIL dbl_counts: corr=%0d uncorr=%0d want 0 1", corr_count_o, uncorr_count_o);
    end
    total++;
    if (last_uncorr_addr_o !== 8'd1) begin
      bad++; $display("FAIL dbl_addr: got %0d want 1", last_uncorr_addr_o);
    end
    total++;
    if (n_wr - wb !== 0) begin bad++; $display("FAIL dbl_writes: got %0d want 0", n_wr - wb); end
  endtask

  task automatic test_grant_hold();
    int cyc; int stall; int wb; int rb;
    logic [25:0] prev;
    load_img(16'h0080, 16'h0000, 16'h0000, 16'h0000);
    hold_n = 5; wb = n_wr; rb = n_rd; stall = 0; cyc = 0;
    pulse_start();
    prev = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
    while (done_o !== 1'b1 && cyc < 500) begin
      @(posedge clk_i); #1;
      cyc++;
      start_i = (cyc == 20);
      if (prev[25] && !mem_gnt_i) begin
        stall++;
        total++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== prev) begin
          bad++;
          $display("FAIL hold_stable: got req=%b we=%b addr=%h wd=%h want %h", mem_req_o,
                   mem_we_o, mem_addr_o, mem_wdata_o, prev);
        end
      end
      prev = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
    end
    start_i = 1'b0;
    hold_n = 0;
    total++;
    if (cyc !== 42) begin bad++; $display("FAIL hold_done_time: got %0d want 42", cyc); end
    total++;
    if (stall !== 25) begin bad++; $display("FAIL hold_stalls: got %0d want 25", stall); end
    total++;
    if (n_wr - wb !== 1 || wr_addr_log[wb] !== 8'd0 || wr_data_log[wb] !== 16'h0000) begin
      bad++;
      $display("FAIL hold_write: n=%0d addr=%h data=%h want 1 00 0000", n_wr - wb,
               wr_addr_log[wb], wr_data_log[wb]);
    end
    total++;
    if (corr_count_o !== 16'd1 || n_rd - rb !== 4) begin
      bad++;
      $display("FAIL hold_midstart: corr=%0d reads=%0d want 1 4", corr_count_o, n_rd - rb);
    end
    total++;
    if (last_uncorr_addr_o !== 8'd1 || uncorr_count_o !== 16'd0) begin
      bad++;
      $display("FAIL hold_retain: last=%0d uncorr=%0d want 1 0", last_uncorr_addr_o, uncorr_count_o);
    end
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL hold_no_restart: busy=%b want 0", busy_o); end
  endtask

  task automatic test_reset_midpass();
    int cyc; int wb; int ib; int rb; bit found;
    load_img(16'h0000, 16'h0024, 16'h0000, 16'h0000);
    rv_delay = 3; wb = n_wr; ib = irq_cnt; found = 1'b0; cyc = 0;
    pulse_start();
    while (!found && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
      if (busy_o === 1'b1 && mem_req_o === 1'b0 && mem_addr_o === 8'd2) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rst_reach_rdwait: got 0 want 1"); end
    total++;
    if (uncorr_count_o !== 16'd1 || last_uncorr_addr_o !== 8'd1) begin
      bad++;
      $display("FAIL rst_pre: uncorr=%0d last=%0d want 1 1", uncorr_count_o, last_uncorr_addr_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    total++;
    if ({busy_o, done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, corr_count_o,
         uncorr_count_o, last_uncorr_addr_o, err_irq_o} !== '0) begin
      bad++;
      $display("FAIL rst_mid_state: busy=%b req=%b addr=%h uncorr=%0d last=%0d want all 0",
               busy_o, mem_req_o, mem_addr_o, uncorr_count_o, last_uncorr_addr_o);
    end
    repeat (6) @(posedge clk_i);
    #1;
    total++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || irq_cnt - ib !== 1 || n_wr - wb !== 0) begin
      bad++;
      $display("FAIL rst_late_rvalid: busy=%b req=%b irqs=%0d writes=%0d want 0 0 1 0",
               busy_o, mem_req_o, irq_cnt - ib, n_wr - wb);
    end
    rv_delay = 1; rb = n_rd;
    pulse_start();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 8'd0) begin
      bad++;
      $display("FAIL rst_restart_req: req=%b addr=%h want 1 00", mem_req_o, mem_addr_o);
    end
    wait_done(cyc);
    total++;
    if (cyc !== 16 || rd_log[rb] !== 8'd0) begin
      bad++;
      $display("FAIL rst_restart_pass: cyc=%0d first_addr=%0d want 16 0", cyc, rd_log[rb]);
    end
    total++;
    if (uncorr_count_o !== 16'd1) begin
      bad++; $display("FAIL rst_restart_uncorr: got %0d want 1", uncorr_count_o);
    end
  endtask

  initial begin
    load_img(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_clean();
    test_single_bit7();
    test_single_bit0();
    test_double();
    test_grant_hold();
    test_reset_midpass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_scrubber.md
# hamming_scrubber

Background ECC scrubber for a memory holding 16-bit Hamming(15,11)+overall-parity (SECDED) codewords. On `start`, it walks addresses 0..DEPTH-1 and reads each word. It checks the syndrome, writes back corrected data on a single-bit error, and logs double-bit errors. It sits between the memory arbiter (as one requester) and the status/IRQ register block.

## Interface
- `DEPTH`, 256: number of words scrubbed per pass (≥2).
- `ADDR_W`, 8: address width; `2**ADDR_W >= DEPTH`.
- `PAUSE_CYCLES`, 16: idle cycles between words, to limit bandwidth; 0 means no pause.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a pass. Ignored unless the block is in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a pass.
- `mem_req` out 1: memory request; held until granted.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out ADDR_W: request address.
- `mem_wdata` out 16: corrected codeword. Valid during a write request.
- `mem_gnt` in 1: request accepted in any cycle where `mem_req & mem_gnt`.
- `mem_rvalid` in 1: read data valid, ≥1 cycle after the read grant.
- `mem_rdata` in 16: read codeword.
- `corr_count` out 16: single-bit errors corrected this pass; saturating.
- `uncorr_count` out 16: double-bit errors detected this pass; saturating.
- `last_uncorr_addr` out ADDR_W: address of the most recent double-bit error.
- `err_irq` out 1: one-cycle pulse on each double-bit error.

## Operation
- Codeword layout:
  - bit 0 is overall parity.
  - bits 1, 2, 4, 8 are Hamming parity bits.
  - bits 3, 5–7, 9–15 are data.
- Syndrome is computed on the captured word `w`:
  - `pos[3:0]` = XOR of index i over all i in 1..15 with `w[i]=1`.
  - `par` = XOR of all 16 bits.
- Classification:
  - `pos==0 && par==0`: clean.
  - `par==1`: single error at bit `pos`; `pos==0` means bit 0. The corrected word is `w` with bit `pos` flipped.
  - `pos!=0 && par==0`: double error, uncorrectable, never written back.
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, ADV, PAUSE.
  - IDLE: on `start`, clear `addr`, `corr_count`, `uncorr_count` and go to RD_REQ. `last_uncorr_addr` is retained.
  - RD_REQ: `mem_req=1`, `mem_we=0`, `mem_addr=addr`. On grant go to RD_WAIT.
  - RD_WAIT: capture `mem_rdata` into `w` on `mem_rvalid`, then go to CHECK. `mem_rvalid` outside RD_WAIT is ignored.
  - CHECK: one cycle of classification.
    - Clean: go to ADV.
    - Single error: `corr_count` +1, load `mem_wdata`, go to WR_REQ.
    - Double error: `uncorr_count` +1, `last_uncorr_addr=addr`, pulse `err_irq`, go to ADV.
  - WR_REQ: `mem_req=1`, `mem_we=1`, `mem_addr=addr`, `mem_wdata` stable until grant. On grant go to ADV.
  - ADV:
    - If `addr==DEPTH-1`: pulse `done`, go to IDLE.
    - Else: `addr` +1. Go to PAUSE if `PAUSE_CYCLES>0`, otherwise RD_REQ.
  - PAUSE: counts PAUSE_CYCLES cycles with `mem_req=0`, then goes to RD_REQ.
- Counters saturate at 0xFFFF and do not wrap.
- `start` while `busy` has no effect. There is no abort; `rst` is the only way to stop a pass.

## Timing
- Reset values:
  - State IDLE; `addr` 0; `busy` 0; `done` 0; `err_irq` 0.
  - `mem_req` 0; `mem_we` 0; `mem_addr` 0; `mem_wdata` 0.
  - `corr_count`, `uncorr_count`, `last_uncorr_addr`: all 0.
- Reset mid-pass: all outputs take their reset values the next cycle. `mem_req` drops even if the request was never granted. Any outstanding read data is ignored.
- `start` at cycle T puts `busy` and `mem_req` high at T+1.
- Request timing:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered outputs.
  - They must not change while `mem_req=1 && !mem_gnt`.
  - `mem_req` drops the cycle after the grant.
- Best-case per-word timing, with gnt in the first request cycle and rvalid one cycle after gnt:
  - Clean word: RD_REQ, RD_WAIT, CHECK, ADV = 4 cycles + PAUSE_CYCLES.
  - Corrected word: +1 cycle for WR_REQ.
- `done` is asserted in the same cycle `busy` drops.
- Counter updates and `err_irq` are visible the cycle after CHECK.

## Test plan
- DEPTH=4, PAUSE_CYCLES=0, all words 0x0000, gnt tied high, rvalid 1 cycle after gnt:
  - 4 reads at addresses 0..3, no writes.
  - `done` pulses 16 cycles after `start`; both counts 0.
- Word at address 2 is 0x0000 with bit 7 flipped (0x0080):
  - Write to address 2 with `mem_wdata=0x0000`.
  - `corr_count=1`, `err_irq` never asserts.
- Word 0x0001 (only bit 0 set): corrected to 0x0000 and written back; `corr_count=1`.
- Word 0x0024 (bits 2 and 5 set):
  - `err_irq` pulses once; `uncorr_count=1`, `last_uncorr_addr=<addr>`.
  - No write is issued.
- Grant withheld for 5 cycles during both RD_REQ and WR_REQ:
  - `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable throughout.
  - A `start` pulse during the pass is ignored.
- Reset asserted while in RD_WAIT:
  - Next cycle: `busy=0`, `mem_req=0`, counts 0.
  - A late `mem_rvalid` produces no effect.
  - A following `start` restarts at address 0.
